unary_frame_tx: RTL

- Transmit-side counterpart of the 64-input ones-counter, which reduces a 64-bit window to a 7-bit population count.
- This block takes a count N (0..64) over a valid/ready handshake and serialises a 64-beat unary frame containing exactly N ones.
- Sits upstream of the counting datapath; feeds stochastic/unary bitstream paths and closes the loop for count-based self-test.

---
 rtl/unary_pkg.sv | 18 +
 rtl/unary_bit_gen.sv | 39 +++
 rtl/unary_frame_tx.sv | 103 ++++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// Shared types and constants for the unary frame transmitter.
// Latency: n/a (package only).
// Backpressure: n/a.
package unary_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int unsigned FRAME_LEN_DEF = 64;

  // Width needed to hold a count in 0..frame_len inclusive.
  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/unary_bit_gen.sv
// Per-beat bit decision for the unary frame serialiser (thermometer or Bresenham).
// Latency: purely combinational.
// Backpressure: none; the caller advances idx/acc only on a transferred beat.
// Build option: UNARY_SPREAD_EN selects Bresenham spreading instead of the thermometer pattern.
module unary_bit_gen #(
  parameter int unsigned CNT_W = 7
`ifdef UNARY_SPREAD_EN
  , parameter int unsigned FRAME_LEN = 64
`endif
) (
`ifdef UNARY_SPREAD_EN
  input  logic [CNT_W-1:0] acc,
  output logic [CNT_W-1:0] acc_nxt,
`else
  input  logic [CNT_W-1:0] idx,
`endif
  input  logic [CNT_W-1:0] cnt_q,
  output logic             beat_bit
);

`ifdef UNARY_SPREAD_EN
  localparam logic [CNT_W:0] LEN_W = (CNT_W+1)'(FRAME_LEN);

  logic [CNT_W:0] sum;

  // Bresenham step: acc stays below FRAME_LEN, so one subtraction re-normalises it.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, cnt_q};
    beat_bit = (sum >= LEN_W);
    acc_nxt  = beat_bit ? CNT_W'(sum - LEN_W) : sum[CNT_W-1:0];
  end
`else
  // Thermometer: the first cnt_q beats of the frame are ones.
  always_comb begin
    beat_bit = (idx < cnt_q);
  end
`endif

endmodule

// File: rtl/unary_frame_tx.sv
// Serialises a count N (0..FRAME_LEN) into a FRAME_LEN-beat unary frame holding exactly N ones.
// Latency: first beat valid the cycle after the count is accepted; back-to-back frames have no bubble.
// Backpressure: beats hold under bit_ready_i=0; cnt_ready_o is combinational from bit_ready_i on the last beat.
// Build option: UNARY_SPREAD_EN spreads the ones evenly (Bresenham) instead of a thermometer pattern.
module unary_frame_tx
  import unary_pkg::*;
#(
  parameter  int unsigned FRAME_LEN = FRAME_LEN_DEF,
  localparam int unsigned CNT_W     = cnt_width(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_valid_i,
  output logic             cnt_ready_o,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             bit_valid_o,
  input  logic             bit_ready_i,
  output logic             bit_o,
  output logic             bit_last_o,
  output logic             sat_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             beat_bit;
  logic             last_beat;
  logic             accept;
  logic [CNT_W-1:0] cnt_clamped;
`ifdef UNARY_SPREAD_EN
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nxt;
`endif

  unary_bit_gen #(
    .CNT_W    (CNT_W)
`ifdef UNARY_SPREAD_EN
    , .FRAME_LEN(FRAME_LEN)
`endif
  ) u_bit_gen (
`ifdef UNARY_SPREAD_EN
    .acc      (acc),
    .acc_nxt  (acc_nxt),
`else
    .idx      (idx),
`endif
    .cnt_q    (cnt_q),
    .beat_bit (beat_bit)
  );

  // Handshake decode: a new count may be taken while the final beat is leaving.
  always_comb begin
    last_beat   = (state == EMIT) && (idx == LAST_IDX);
    cnt_ready_o = (state == IDLE) || (last_beat && bit_ready_i);
    accept      = cnt_valid_i && cnt_ready_o;
    cnt_clamped = (cnt_i > LEN_C) ? LEN_C : cnt_i;
    bit_valid_o = (state == EMIT);
    busy_o      = (state == EMIT);
    bit_o       = (state == EMIT) && beat_bit;
    bit_last_o  = last_beat;
    sat_o       = sat_q;
  end

  // Frame sequencer: latch counts, step the beat index on every transferred beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
`ifdef UNARY_SPREAD_EN
      acc   <= '0;
`endif
    end else begin
      sat_q <= 1'b0;
      if (accept) begin
        state <= EMIT;
        idx   <= '0;
        cnt_q <= cnt_clamped;
        sat_q <= (cnt_i > LEN_C);
`ifdef UNARY_SPREAD_EN
        acc   <= '0;
`endif
      end else if ((state == EMIT) && bit_ready_i) begin
        if (last_beat) begin
          state <= IDLE;
          idx   <= '0;
        end else begin
          idx   <= idx + CNT_W'(1);
`ifdef UNARY_SPREAD_EN
          acc   <= acc_nxt;
`endif
        end
      end
    end
  end

endmodule
